systolic_block_ctrl: RTL and testbench

- Block-framing and command controller for the 4-bit systolic tile.
- Tracks the 16-cycle block counter, deserialises the column and row control bit streams into 16-bit headers, and arbitrates between the two command sources.
- Issues one decoded register-access command at a time (internal state, A, B, C words, pipeline stages) to the tile datapath.
- Owns the continuous-mode pipeline counter.

---
 rtl/systolic_block_ctrl_if.sv | 37 +++
 rtl/systolic_block_ctrl.sv | 183 ++++++++++++++++++
 tb/tb_systolic_block_ctrl.sv | 217 +++++++++++++++++++++
 3 files changed

// File: rtl/systolic_block_ctrl_if.sv
// Control-stream inputs and decoded command outputs of the systolic tile block controller.
interface systolic_block_ctrl_if;
  logic        ena;
  logic        col_ctrl_in;
  logic        row_ctrl_in;
  logic [3:0]  count;
  logic        block_end;
  logic [15:0] col_hdr;
  logic [15:0] row_hdr;
  logic        cmd_valid;
  logic        cmd_src;
  logic [7:0]  cmd_addr;
  logic        cmd_write;
  logic        cmd_read;
  logic [2:0]  cmd_target;
  logic [3:0]  cmd_index;
  logic [15:0] stage_en;
  logic        collision;
  logic        addr_err;
  logic        continuous;
  logic [3:0]  pipe_count;
  logic        pipe_synced;

  modport slave (
    input  ena, col_ctrl_in, row_ctrl_in,
    output count, block_end, col_hdr, row_hdr,
           cmd_valid, cmd_src, cmd_addr, cmd_write, cmd_read, cmd_target, cmd_index,
           stage_en, collision, addr_err, continuous, pipe_count, pipe_synced
  );

  modport master (
    output ena, col_ctrl_in, row_ctrl_in,
    input  count, block_end, col_hdr, row_hdr,
           cmd_valid, cmd_src, cmd_addr, cmd_write, cmd_read, cmd_target, cmd_index,
           stage_en, collision, addr_err, continuous, pipe_count, pipe_synced
  );
endinterface

// File: rtl/systolic_block_ctrl.sv
// Block framing, serial header capture, column/row command arbitration and decode,
// and continuous-mode pipeline counter for the 4-bit systolic tile.
module systolic_block_ctrl #(
  parameter int BLOCK_LEN = 16,
  parameter int ADDR_W    = 8
) (
  input logic                  clk,
  input logic                  rst_n,
  systolic_block_ctrl_if.slave bus
);
  localparam int                CNT_W = $clog2(BLOCK_LEN);
  localparam int                HDR_W = ADDR_W + 8;
  localparam logic [CNT_W-1:0]  LAST  = CNT_W'(BLOCK_LEN - 1);

  typedef enum logic [2:0] {
    TGT_NONE  = 3'd0,
    TGT_STATE = 3'd1,
    TGT_A     = 3'd2,
    TGT_B     = 3'd3,
    TGT_C     = 3'd4,
    TGT_STAGE = 3'd5
  } target_e;

  // Header without the reserved low bits.
  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic              valid;
    logic              read;
    logic              write;
    logic              run;
    logic              stop;
  } hdr_ctl_t;

  typedef struct packed {
    logic              valid;
    logic              src;
    logic [ADDR_W-1:0] addr;
    logic              write;
    logic              read;
    target_e           target;
    logic [3:0]        index;
    logic              run;
    logic              stop;
    logic              collision;
    logic              addr_err;
  } cmd_t;

  function automatic cmd_t decode(input hdr_ctl_t h, input logic src, input logic coll);
    cmd_t c;
    c           = '0;
    c.valid     = h.valid;
    c.src       = src;
    c.addr      = h.addr;
    c.write     = h.write;
    c.read      = h.read & ~h.write;
    c.run       = h.run;
    c.stop      = h.stop;
    c.collision = coll;
    if (h.addr == 8'h01)            c.target = TGT_STATE;
    else if (h.addr == 8'h02)       c.target = TGT_A;
    else if (h.addr == 8'h04)       c.target = TGT_B;
    else if (h.addr[7:3] == 5'b00001) begin
      c.target = TGT_C;
      c.index  = {1'b0, h.addr[2:0]};
    end else if (h.addr[7:4] == 4'h1) begin
      c.target = TGT_STAGE;
      c.index  = h.addr[3:0];
    end else begin
      c.addr_err = h.read | h.write;
    end
    return c;
  endfunction

  logic [CNT_W-1:0] count_q, count_d;
  logic [HDR_W-2:0] col_buf_q, col_buf_d, row_buf_q, row_buf_d;
  logic [HDR_W-1:0] col_hdr_q, col_hdr_d, row_hdr_q, row_hdr_d;
  logic             pend_q, pend_d;
  cmd_t             cmd_q, cmd_d;
  logic             continuous_q, continuous_d;
  logic [CNT_W-1:0] pipe_count_q, pipe_count_d;

  logic [HDR_W-1:0] col_next, row_next;
  hdr_ctl_t         col_f, row_f, row_pend_f;

  assign col_next   = {col_buf_q, bus.col_ctrl_in};
  assign row_next   = {row_buf_q, bus.row_ctrl_in};
  assign col_f      = hdr_ctl_t'(col_next[HDR_W-1:3]);
  assign row_f      = hdr_ctl_t'(row_next[HDR_W-1:3]);
  assign row_pend_f = hdr_ctl_t'(row_hdr_q[HDR_W-1:3]);

  always_comb begin
    // NOTE: every variable gets its hold value first so no path can infer a latch.
    count_d      = count_q;
    col_buf_d    = col_buf_q;
    row_buf_d    = row_buf_q;
    col_hdr_d    = col_hdr_q;
    row_hdr_d    = row_hdr_q;
    pend_d       = pend_q;
    cmd_d        = cmd_q;
    continuous_d = continuous_q;
    pipe_count_d = pipe_count_q;

    if (bus.ena) begin
      count_d   = count_q + 1'b1;
      col_buf_d = col_next[HDR_W-2:0];
      row_buf_d = row_next[HDR_W-2:0];
      cmd_d     = '0;

      if (count_q == LAST) begin
        col_hdr_d = col_next;
        row_hdr_d = row_next;
        pend_d    = 1'b0;
        if (col_f.valid) begin
          cmd_d  = decode(col_f, 1'b0, row_f.valid && (row_f.addr == col_f.addr));
          pend_d = row_f.valid && (row_f.addr != col_f.addr);
        end else if (row_f.valid) begin
          cmd_d = decode(row_f, 1'b1, 1'b0);
        end
      end else if (count_q == '0 && pend_q) begin
        cmd_d  = decode(row_pend_f, 1'b1, 1'b0);
        pend_d = 1'b0;
      end

      // The command currently presented steers continuous mode; stop beats run.
      if (cmd_q.valid && cmd_q.stop) begin
        continuous_d = 1'b0;
      end else if (cmd_q.valid && cmd_q.run) begin
        continuous_d = 1'b1;
        pipe_count_d = count_q + 1'b1;
      end else if (continuous_q) begin
        pipe_count_d = pipe_count_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q      <= '0;
      col_buf_q    <= '0;
      row_buf_q    <= '0;
      col_hdr_q    <= '0;
      row_hdr_q    <= '0;
      pend_q       <= 1'b0;
      cmd_q        <= '0;
      continuous_q <= 1'b0;
      pipe_count_q <= '0;
    end else begin
      // NOTE: non-blocking so every flop samples the pre-edge value of its neighbours.
      count_q      <= count_d;
      col_buf_q    <= col_buf_d;
      row_buf_q    <= row_buf_d;
      col_hdr_q    <= col_hdr_d;
      row_hdr_q    <= row_hdr_d;
      pend_q       <= pend_d;
      cmd_q        <= cmd_d;
      continuous_q <= continuous_d;
      pipe_count_q <= pipe_count_d;
    end
  end

  // A held command stays in cmd_q while ena is low but is only presented when ena is high.
  logic show;
  assign show = bus.ena & cmd_q.valid;

  assign bus.count       = count_q;
  assign bus.block_end   = (count_q == LAST);
  assign bus.col_hdr     = col_hdr_q;
  assign bus.row_hdr     = row_hdr_q;
  assign bus.cmd_valid   = show;
  assign bus.cmd_src     = show & cmd_q.src;
  assign bus.cmd_addr    = show ? cmd_q.addr : '0;
  assign bus.cmd_write   = show & cmd_q.write;
  assign bus.cmd_read    = show & cmd_q.read;
  assign bus.cmd_target  = show ? cmd_q.target : TGT_NONE;
  assign bus.cmd_index   = show ? cmd_q.index : '0;
  assign bus.stage_en    = (show && cmd_q.target == TGT_STAGE && cmd_q.write)
                           ? (16'd1 << cmd_q.addr[3:0]) : '0;
  assign bus.collision   = show & cmd_q.collision;
  assign bus.addr_err    = show & cmd_q.addr_err;
  assign bus.continuous  = continuous_q;
  assign bus.pipe_count  = pipe_count_q;
  assign bus.pipe_synced = continuous_q && (pipe_count_q == count_q);
endmodule

// File: tb/tb_systolic_block_ctrl.sv
// Scoreboard bench for systolic_block_ctrl: block-level reference model, randomized headers
// with ena gaps, and a monitor that pops expected commands whenever cmd_valid is seen.
module tb_systolic_block_ctrl;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  systolic_block_ctrl_if bus();
  systolic_block_ctrl dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  typedef struct packed {
    logic [3:0]  cnt;
    logic        src;
    logic [7:0]  addr;
    logic        wr;
    logic        rd;
    logic [2:0]  tgt;
    logic [3:0]  idx;
    logic [15:0] sen;
    logic        coll;
    logic        aerr;
  } exp_t;

  exp_t sbq[$];
  int   n_vec = 0;
  int   n_bad = 0;

  // Reference model state
  int          m_count;
  logic        m_cont;
  int          m_pipe;
  logic [15:0] m_col, m_row;
  logic [15:0] blk_ch, blk_rh;
  bit          s_v[2], s_run[2], s_stop[2];

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic exp_t mk_cmd(input logic [15:0] h, input logic src, input logic coll, input int cnt);
    exp_t e;
    int   a;
    e      = '0;
    a      = int'(h[15:8]);
    e.cnt  = 4'(cnt);
    e.src  = src;
    e.addr = h[15:8];
    e.wr   = h[5];
    e.rd   = h[6] & ~h[5];
    e.coll = coll;
    if (a == 1)                 e.tgt = 3'd1;
    else if (a == 2)            e.tgt = 3'd2;
    else if (a == 4)            e.tgt = 3'd3;
    else if (a >= 8 && a <= 15) begin e.tgt = 3'd4; e.idx = 4'(a - 8);  end
    else if (a >= 16 && a <= 31) begin e.tgt = 3'd5; e.idx = 4'(a - 16); end
    else                        e.aerr = h[6] | h[5];
    if (e.tgt == 3'd5 && e.wr) e.sen = 16'(1) << e.idx;
    return e;
  endfunction

  function automatic void plan_block(input logic [15:0] ch, input logic [15:0] rh);
    s_v = '{0, 0}; s_run = '{0, 0}; s_stop = '{0, 0};
    if (ch[7]) begin
      sbq.push_back(mk_cmd(ch, 1'b0, rh[7] && rh[15:8] == ch[15:8], 0));
      s_v[0] = 1; s_run[0] = ch[4]; s_stop[0] = ch[3];
      if (rh[7] && rh[15:8] != ch[15:8]) begin
        sbq.push_back(mk_cmd(rh, 1'b1, 1'b0, 1));
        s_v[1] = 1; s_run[1] = rh[4]; s_stop[1] = rh[3];
      end
    end else if (rh[7]) begin
      sbq.push_back(mk_cmd(rh, 1'b1, 1'b0, 0));
      s_v[0] = 1; s_run[0] = rh[4]; s_stop[0] = rh[3];
    end
  endfunction

  function automatic void reset_model();
    m_count = 0; m_cont = 0; m_pipe = 0; m_col = '0; m_row = '0;
    s_v = '{0, 0}; s_run = '{0, 0}; s_stop = '{0, 0};
    sbq.delete();
  endfunction

  // One enabled cycle of the block-level model, applied before the clock edge.
  function automatic void advance();
    int c;
    c = m_count;
    if (c < 2 && s_v[c]) begin
      if (s_stop[c])     m_cont = 1'b0;
      else if (s_run[c]) m_cont = 1'b1;
    end
    if (c == 15) begin
      m_col = blk_ch;
      m_row = blk_rh;
      plan_block(blk_ch, blk_rh);
    end
    m_count = (c + 1) % 16;
    if (m_cont) m_pipe = m_count;
  endfunction

  task automatic check_state();
    check("state",
          {bus.count, bus.block_end, bus.col_hdr, bus.row_hdr, bus.continuous, bus.pipe_count, bus.pipe_synced},
          {4'(m_count), logic'(m_count == 15), m_col, m_row, m_cont, 4'(m_pipe), m_cont});
  endtask

  task automatic step(input logic e, input logic cb, input logic rb);
    bus.ena = e; bus.col_ctrl_in = cb; bus.row_ctrl_in = rb;
    if (e) advance();
    @(posedge clk); #1;
    check_state();
  endtask

  task automatic send_block(input logic [15:0] ch, input logic [15:0] rh, input int gap);
    blk_ch = ch; blk_rh = rh;
    for (int k = 0; k < 16; k++) begin
      while (gap > 0 && $urandom_range(99) < gap) step(1'b0, 1'($urandom), 1'($urandom));
      step(1'b1, ch[15-k], rh[15-k]);
    end
  endtask

  function automatic logic [15:0] rand_hdr();
    logic [7:0] a, lo;
    case ($urandom_range(5))
      0:       a = 8'h01;
      1:       a = 8'h02;
      2:       a = 8'h04;
      3:       a = 8'h08 + 8'($urandom_range(7));
      4:       a = 8'h10 + 8'($urandom_range(15));
      default: a = 8'($urandom);
    endcase
    lo    = 8'($urandom);
    lo[7] = ($urandom_range(3) != 0);
    lo[4] = ($urandom_range(5) == 0);
    lo[3] = ($urandom_range(7) == 0);
    return {a, lo};
  endfunction

  // Monitor: pops one expectation per presented command, checks idle fields otherwise.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (bus.cmd_valid) begin
          if (sbq.size() == 0) begin
            n_vec++;
            n_bad++;
            $display("FAIL cmd_unexpected: got cmd addr %h src %b at count %0d, expected none",
                     bus.cmd_addr, bus.cmd_src, bus.count);
          end else begin
            e = sbq.pop_front();
            check("cmd", {bus.count, bus.cmd_src, bus.cmd_addr, bus.cmd_write, bus.cmd_read,
                          bus.cmd_target, bus.cmd_index, bus.stage_en, bus.collision, bus.addr_err}, e);
          end
        end else begin
          check("idle_fields", {bus.cmd_src, bus.cmd_addr, bus.cmd_write, bus.cmd_read, bus.cmd_target,
                                bus.cmd_index, bus.stage_en, bus.collision, bus.addr_err}, '0);
        end
      end
    end
  end

  initial begin
    logic [15:0] ch, rh, part;
    bus.ena = 1'b0; bus.col_ctrl_in = 1'b0; bus.row_ctrl_in = 1'b0;
    reset_model();
    blk_ch = '0; blk_rh = '0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    check_state();

    // Idle run: two quiet blocks
    for (int i = 0; i < 32; i++) step(1'b1, 1'b0, 1'b0);

    // Directed headers
    send_block(16'h02A0, 16'h0000, 0);
    send_block(16'h13A0, 16'h08C0, 0);
    send_block(16'h05A0, 16'h05A0, 0);
    send_block(16'h0190, 16'h0000, 0);
    send_block(16'h0000, 16'h0000, 0);
    send_block(16'h0198, 16'h0000, 0);
    send_block(16'h0000, 16'h0000, 0);

    // Randomized blocks with ena gaps
    for (int b = 0; b < 80; b++) begin
      ch = ($urandom_range(4) == 0) ? 16'h0000 : rand_hdr();
      rh = ($urandom_range(4) == 0) ? 16'h0000 : rand_hdr();
      if ($urandom_range(3) == 0) rh[15:8] = ch[15:8];
      send_block(ch, rh, 10);
    end
    send_block(16'h0000, 16'h0000, 0);

    // ena low at count 7, then asynchronous reset at count 9
    part = 16'h13B0;
    for (int k = 0; k < 7; k++) step(1'b1, part[15-k], part[15-k]);
    for (int k = 0; k < 5; k++) step(1'b0, 1'b1, 1'b1);
    for (int k = 7; k < 9; k++) step(1'b1, part[15-k], part[15-k]);
    #2 rst_n = 1'b0;
    #1;
    check("async_reset_a", {bus.count, bus.block_end, bus.col_hdr, bus.row_hdr,
                            bus.continuous, bus.pipe_count, bus.pipe_synced}, '0);
    check("async_reset_b", {bus.cmd_valid, bus.cmd_src, bus.cmd_addr, bus.cmd_write, bus.cmd_read,
                            bus.cmd_target, bus.cmd_index, bus.stage_en, bus.collision, bus.addr_err}, '0);
    reset_model();
    @(posedge clk); #1 rst_n = 1'b1;
    check_state();
    send_block(16'h02A0, 16'h0000, 0);
    send_block(16'h0000, 16'h0000, 0);

    check("sb_empty", 128'(sbq.size()), 128'(0));
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
